axi4_lite_cmd_master: RTL
=========================

Name: axi4_lite_cmd_master

Overview:
Single-outstanding AXI4-lite master that turns simple read/write commands into AXI4-lite transactions.
It sits directly upstream of the AXI4-lite GPIO slave and drives its axi_* bus.
Completion status and read data go back on a response channel.
A saturating error counter supports software and bench visibility.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (a multiple of 8)
ERRCNT_W, 16, width of the saturating error counter

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP
err_count  out  ERRCNT_W  count of non-OKAY responses, saturating
axi_awaddr  out  ADDR_W  write address
axi_awvalid  out  1  write address valid
axi_awready  in  1  write address ready
axi_wdata  out  DATA_W  write data
axi_wstrb  out  DATA_W/8  write strobes
axi_wvalid  out  1  write data valid
axi_wready  in  1  write data ready
axi_bresp  in  2  write response
axi_bvalid  in  1  write response valid
axi_bready  out  1  write response ready
axi_araddr  out  ADDR_W  read address
axi_arvalid  out  1  read address valid
axi_arready  in  1  read address ready
axi_rdata  in  DATA_W  read data
axi_rresp  in  2  read response
axi_rvalid  in  1  read data valid
axi_rready  out  1  read data ready

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE.
  - All valid/ready outputs are 0, except cmd_ready, which is 1 once out of reset.
  - Address, data, rsp_* and err_count outputs are 0.
- Reset mid-transaction aborts immediately. The bus is assumed reset together with the slave.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- cmd_ready=1 only in IDLE. Command accepted on cmd_valid&&cmd_ready.
- On acceptance, register addr, wdata, wstrb and write.
  - Write: go to WR_ADDR_DATA and set awvalid=wvalid=1 next cycle.
  - Read: go to RD_ADDR and set arvalid=1 next cycle.
- WR_ADDR_DATA:
  - AW and W are tracked by independent done flags.
  - awvalid drops the cycle after the awready handshake; wvalid likewise after wready.
  - When both are done (same cycle or different cycles), go to WR_RESP.
  - Never deassert a valid before its handshake. Hold addr/data stable while valid.
- WR_RESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0 and go to RSP.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RSP.
- RSP:
  - rsp_valid=1; all rsp_* fields are held stable until rsp_ready.
  - On rsp_ready, go to IDLE (cmd_ready=1 next cycle).
- Latency against a zero-wait slave, with accept at cycle 0:
  - Write: AW/W handshake cycle 1, B handshake cycle 2, rsp_valid cycle 3.
  - Read: AR handshake cycle 1, R cycle 2, rsp_valid cycle 3.
- err_count increments by 1 when RSP is entered with resp!=OKAY (SLVERR or DECERR). It saturates at all-ones.
- Only one transaction is outstanding at a time. No bursts; AXI4-lite only.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - Response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The state encoding for this block.
- No sub-module; single flat module.

Test Plan:
- Write cmd addr=0x0, wdata=0xA5A5_0001, wstrb=0xF to a zero-wait slave with bresp=OKAY -> AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3 with rsp_write=1, rsp_resp=0, err_count=0.
- Slave holds awready low for 3 cycles while wready is immediate -> wvalid drops after cycle 1, awvalid stays high with awaddr stable until its handshake, then one B handshake.
- Read addr=0x0 with slave returning rdata=0x1234_5678 after 2 wait cycles -> rsp_rdata=0x1234_5678, rsp_resp=0, arvalid high for exactly 1 handshake.
- Slave returns bresp=SLVERR on 3 consecutive writes -> err_count=3; with ERRCNT_W=2 forced, 4 errors -> err_count holds at 3.
- rsp_ready held low 5 cycles -> rsp_valid and fields stable, cmd_ready=0 throughout; a new cmd_valid is not accepted until the cycle after rsp_ready.
- resetn pulsed low during RD_DATA -> arvalid/rready/rsp_valid go to 0 without waiting for a clock edge, err_count=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite definitions: response codes and
// the command-master state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_RSP
  } state_t;

  function automatic logic is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-lite master: one command in,
// one AXI4-lite transaction out, one response back.
module axi4_lite_cmd_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ERRCNT_W = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ERRCNT_W-1:0]   err_count,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  output logic [ADDR_W-1:0]     axi_araddr,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic [DATA_W-1:0]     axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rvalid,
  output logic                  axi_rready
);

  localparam int STRB_W = DATA_W / 8;

  state_t state;
  state_t state_d;

  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic aw_done;
  logic w_done;

  logic                rsp_write_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [1:0]          rsp_resp_q;
  logic [ERRCNT_W-1:0] err_q;

  logic accept;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;
  logic err_hit;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = axi_awvalid && axi_awready;
  assign w_hs   = axi_wvalid && axi_wready;
  assign b_hs   = axi_bvalid && axi_bready;
  assign r_hs   = axi_rvalid && axi_rready;

  assign err_hit = (b_hs && is_err(axi_bresp))
                || (r_hs && is_err(axi_rresp));

  always_comb begin
    state_d     = state;
    cmd_ready   = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    rsp_valid   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // held low while reset is asserted
        cmd_ready = resetn;
        if (cmd_valid && resetn) begin
          state_d = cmd_write ? ST_WR_ADDR_DATA
                              : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR_DATA: begin
        axi_awvalid = !aw_done;
        axi_wvalid  = !w_done;
        if ((aw_done || axi_awready)
            && (w_done || axi_wready)) begin
          state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        axi_bready = 1'b1;
        if (axi_bvalid) begin
          state_d = ST_RSP;
        end
      end
      ST_RD_ADDR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) begin
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        axi_rready = 1'b1;
        if (axi_rvalid) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  // AW and W complete independently; each valid drops
  // the cycle after its own handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (accept) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else if (b_hs) begin
      rsp_write_q <= 1'b1;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= axi_bresp;
    end else if (r_hs) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= axi_rdata;
      rsp_resp_q  <= axi_rresp;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= '0;
    end else if (err_hit && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = wstrb_q;
  assign rsp_write  = rsp_write_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_resp   = rsp_resp_q;
  assign err_count  = err_q;

  logic unused_write;
  assign unused_write = write_q;

endmodule
